// File: rtl/aes192_pipe_sched.sv
// aes192_pipe_sched: round-robin issue of two requesters into one non-stalling AES-192 pipeline.
// Credits bound in-flight blocks plus FIFO occupancy, so a completing result always has a slot.
module aes192_pipe_sched #(
    parameter int CORE_LAT   = 25,
    parameter int OBUF_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic [191:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
    input  logic [191:0] req1_key,
    output logic [127:0] core_state,
    output logic [191:0] core_key,
    input  logic [127:0] core_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(OBUF_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(OBUF_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(OBUF_DEPTH - 1);

    logic [CORE_LAT-1:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic [CW-1:0]       infl_q, infl_d, cnt_q, cnt_d;
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic                rr_q, rr_d;
    logic [128:0]        mem_q [OBUF_DEPTH];
    logic [CW:0]         used;
    logic                grant_id, issue, push, pop;

    assign used       = {1'b0, infl_q} + {1'b0, cnt_q};
    assign grant_id   = (req0_valid & req1_valid) ? ~rr_q : req1_valid;
    // gating with rst_n keeps ready low while reset is asserted
    assign issue      = rst_n & (req0_valid | req1_valid) & (used < DEPTH_W);
    assign req0_ready = issue & ~grant_id;
    assign req1_ready = issue & grant_id;
    assign core_state = issue ? (grant_id ? req1_state : req0_state) : '0;
    assign core_key   = issue ? (grant_id ? req1_key : req0_key) : '0;
    assign push       = tag_v_q[CORE_LAT-1];
    assign rsp_valid  = cnt_q != '0;
    assign pop        = rsp_valid & rsp_ready;
    assign rsp_data   = rsp_valid ? mem_q[rd_q][127:0] : '0;
    assign rsp_id     = rsp_valid & mem_q[rd_q][128];
    assign busy       = (infl_q != '0) | rsp_valid;

    always_comb begin
        tag_v_d  = {tag_v_q[CORE_LAT-2:0], issue};
        tag_id_d = {tag_id_q[CORE_LAT-2:0], issue & grant_id};
        rr_d     = issue ? grant_id : rr_q;
        infl_d   = infl_q + CW'(issue) - CW'(push);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_d     = push ? ((wr_q == LAST_P) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d     = pop ? ((rd_q == LAST_P) ? '0 : rd_q + PW'(1)) : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
            rr_q     <= 1'b1;
            infl_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            rr_q     <= rr_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {tag_id_q[CORE_LAT-1], core_out};
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == FULL_C));
endmodule
